// File: rtl/atm_multi_account_ctrl.sv
// Multi-account ATM session controller: card/PIN check, withdraw/deposit
// against per-account balances, retry lockout, inactivity timeout and error codes.
module atm_multi_account_ctrl #(
    parameter int NUM_ACCOUNTS   = 4,
    parameter int ID_WIDTH       = 2,
    parameter int PIN_WIDTH      = 16,
    parameter int AMT_WIDTH      = 14,
    parameter int MAX_TRIES      = 3,
    parameter int OUT_LIMIT      = 7000,
    parameter int INIT_BALANCE   = 3000,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cancel,
    input  logic                              next,
    input  logic                              mode,
    input  logic [ID_WIDTH-1:0]               card_id,
    input  logic [PIN_WIDTH-1:0]              pin,
    input  logic [AMT_WIDTH-1:0]              amount_in,
    input  logic [NUM_ACCOUNTS*PIN_WIDTH-1:0] account_pins,
    output logic                              success,
    output logic [AMT_WIDTH-1:0]              cash_out,
    output logic [AMT_WIDTH-1:0]              balance_out,
    output logic [2:0]                        err_code,
    output logic [2:0]                        state_display
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_CHECK_PIN  = 3'd1;
    localparam logic [2:0] S_SELECT_AMT = 3'd2;
    localparam logic [2:0] S_VERIFY     = 3'd3;
    localparam logic [2:0] S_DISPENSE   = 3'd4;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_PIN      = 3'd1;
    localparam logic [2:0] ERR_AMOUNT   = 3'd2;
    localparam logic [2:0] ERR_FUNDS    = 3'd3;
    localparam logic [2:0] ERR_CARD     = 3'd4;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd5;
    localparam logic [2:0] ERR_OVERFLOW = 3'd6;

    localparam int RETRY_W = $clog2(MAX_TRIES + 1);
    localparam int TO_W    = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [RETRY_W-1:0]   MAX_TRIES_C = RETRY_W'(MAX_TRIES);
    localparam logic [TO_W-1:0]      TO_LAST     = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [AMT_WIDTH-1:0] OUT_LIMIT_C = AMT_WIDTH'(OUT_LIMIT);
    localparam logic [AMT_WIDTH-1:0] INIT_BAL_C  = AMT_WIDTH'(INIT_BALANCE);

    logic [2:0]           state_q, state_d;
    logic                 prev_next_q;
    logic [ID_WIDTH-1:0]  card_q, card_d;
    logic [AMT_WIDTH-1:0] amount_q, amount_d;
    logic                 mode_q, mode_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic [TO_W-1:0]      timeout_q, timeout_d;
    logic [2:0]           err_q, err_d;
    logic [AMT_WIDTH-1:0] balance_q [NUM_ACCOUNTS];
    logic [NUM_ACCOUNTS-1:0] lock_q;

    logic                 press;
    logic                 card_ok;
    logic                 active;
    logic [AMT_WIDTH-1:0] cur_balance;
    logic [PIN_WIDTH-1:0] cur_pin;
    logic [AMT_WIDTH:0]   dep_sum;
    logic [RETRY_W-1:0]   retry_inc;
    logic                 bal_we;
    logic [AMT_WIDTH-1:0] bal_wdata;
    logic                 lock_set;

    assign press       = next & ~prev_next_q;
    assign card_ok     = (int'(card_id) < NUM_ACCOUNTS) && !lock_q[card_id];
    assign active      = (state_q == S_CHECK_PIN) || (state_q == S_SELECT_AMT) ||
                         (state_q == S_VERIFY);
    assign cur_balance = balance_q[card_q];
    assign cur_pin     = account_pins[card_q*PIN_WIDTH +: PIN_WIDTH];
    // One extra bit so a deposit that would wrap the balance is caught.
    assign dep_sum     = {1'b0, cur_balance} + {1'b0, amount_q};
    assign retry_inc   = retry_q + RETRY_W'(1);

    // NOTE: every signal gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        card_d    = card_q;
        amount_d  = amount_q;
        mode_d    = mode_q;
        retry_d   = retry_q;
        err_d     = err_q;
        bal_we    = 1'b0;
        bal_wdata = cur_balance;
        lock_set  = 1'b0;

        if (state_q >= S_DISPENSE) begin
            // DISPENSE is a single uninterruptible cycle; illegal codes also recover here.
            state_d = S_IDLE;
        end else if (cancel) begin
            state_d = S_IDLE;
            retry_d = '0;
        end else if (active && !press && (timeout_q == TO_LAST)) begin
            state_d = S_IDLE;
            err_d   = ERR_TIMEOUT;
            retry_d = '0;
        end else if (press) begin
            case (state_q)
                S_IDLE: begin
                    if (card_ok) begin
                        card_d  = card_id;
                        state_d = S_CHECK_PIN;
                        err_d   = ERR_NONE;
                        retry_d = '0;
                    end else begin
                        err_d = ERR_CARD;
                    end
                end
                S_CHECK_PIN: begin
                    if (pin == cur_pin) begin
                        state_d = S_SELECT_AMT;
                        err_d   = ERR_NONE;
                    end else if (retry_inc >= MAX_TRIES_C) begin
                        retry_d  = retry_inc;
                        lock_set = 1'b1;
                        state_d  = S_IDLE;
                        err_d    = ERR_CARD;
                    end else begin
                        retry_d = retry_inc;
                        err_d   = ERR_PIN;
                    end
                end
                S_SELECT_AMT: begin
                    amount_d = amount_in;
                    mode_d   = mode;
                    if ((amount_in == '0) || (amount_in > OUT_LIMIT_C)) begin
                        err_d = ERR_AMOUNT;
                    end else begin
                        state_d = S_VERIFY;
                    end
                end
                S_VERIFY: begin
                    if (!mode_q && (amount_q > cur_balance)) begin
                        state_d = S_IDLE;
                        err_d   = ERR_FUNDS;
                    end else if (mode_q && dep_sum[AMT_WIDTH]) begin
                        state_d = S_IDLE;
                        err_d   = ERR_OVERFLOW;
                    end else begin
                        state_d   = S_DISPENSE;
                        bal_we    = 1'b1;
                        bal_wdata = mode_q ? dep_sum[AMT_WIDTH-1:0] : (cur_balance - amount_q);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        timeout_d = (active && !press && (state_d == state_q)) ? (timeout_q + TO_W'(1)) : '0;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            prev_next_q <= 1'b0;
            card_q      <= '0;
            amount_q    <= '0;
            mode_q      <= 1'b0;
            retry_q     <= '0;
            timeout_q   <= '0;
            err_q       <= ERR_NONE;
            lock_q      <= '0;
            // NOTE: the balance array is a small register file that must come
            // out of reset holding the opening balance, so it is reset explicitly.
            for (int k = 0; k < NUM_ACCOUNTS; k++) begin
                balance_q[k] <= INIT_BAL_C;
            end
        end else begin
            state_q     <= state_d;
            prev_next_q <= next;
            card_q      <= card_d;
            amount_q    <= amount_d;
            mode_q      <= mode_d;
            retry_q     <= retry_d;
            timeout_q   <= timeout_d;
            err_q       <= err_d;
            if (bal_we) begin
                balance_q[card_q] <= bal_wdata;
            end
            if (lock_set) begin
                lock_q[card_q] <= 1'b1;
            end
        end
    end

    assign success       = (state_q == S_DISPENSE);
    assign cash_out      = (success && !mode_q) ? amount_q : '0;
    assign balance_out   = cur_balance;
    assign err_code      = err_q;
    assign state_display = state_q;

endmodule
